pc_sequencer: RTL and testbench

//  Program-counter controller for the single-cycle core. Owns the PC register and the
//  run/halt state. Sequences fetch as straight-line increment, absolute jump or relative branch.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the program-counter sequencer and its surroundings:
// decoder/ALU flags in, branch-table lookup, fetch address and status out.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             halt_req;
  logic             br_req;
  logic             br_taken;
  logic             br_abs;
  logic [4:0]       br_ptr;
  logic [4:0]       lut_ptr;
  logic [7:0]       lut_dout;
  logic [PC_W-1:0]  pc;
  logic             flush;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, stall, halt_req, br_req, br_taken, br_abs, br_ptr, lut_dout,
    input  lut_ptr, pc, flush, busy, done, instr_cnt
  );

  modport slave (
    input  start, stall, halt_req, br_req, br_taken, br_abs, br_ptr, lut_dout,
    output lut_ptr, pc, flush, busy, done, instr_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC and run/halt state, sequencing fetch as
// increment, absolute jump or PC-relative branch with targets from the branch table.
module pc_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 1023,
  parameter int CNT_W      = 16
) (
  input logic           CLK,
  input logic           Reset_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] END_PC   = PC_W'(END_ADDR);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [PC_W-1:0]  abs_target, rel_target;
  logic             flush_q, busy_q, done_q;

  // Absolute targets are an unsigned table entry; relative offsets are signed.
  assign abs_target = PC_W'(bus.lut_dout);
  assign rel_target = pc + PC_W'($signed(bus.lut_dout));
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          cnt_nxt = cnt_inc;
          if (bus.halt_req) begin
            state_nxt = DONE;
          end else if (bus.br_req && bus.br_taken) begin
            pc_nxt    = bus.br_abs ? abs_target : rel_target;
            state_nxt = FLUSH;
          end else if (pc == END_PC) begin
            state_nxt = DONE;
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      FLUSH: begin
        if (!bus.stall) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pc      <= START_PC;
      cnt     <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      flush_q <= (state_nxt == FLUSH);
      busy_q  <= (state_nxt == RUN) || (state_nxt == FLUSH);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.lut_ptr   = bus.br_ptr;
  assign bus.pc        = pc;
  assign bus.flush     = flush_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed stimulus with a scoreboard of
// expected PC/status/count values, compared one cycle after each drive.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 5;

  typedef struct {
    int unsigned pc;
    bit          flush;
    bit          busy;
    bit          done;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .START_ADDR(0), .END_ADDR(1023), .CNT_W(CNT_W)) dut (
    .CLK    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".pc"},    32'(bus.pc),        e.pc);
    check({tag, ".flush"}, 32'(bus.flush),     32'(e.flush));
    check({tag, ".busy"},  32'(bus.busy),      32'(e.busy));
    check({tag, ".done"},  32'(bus.done),      32'(e.done));
    check({tag, ".cnt"},   32'(bus.instr_cnt), e.cnt);
  endtask

  task automatic drive(input bit start, input bit stall, input bit halt, input bit br,
                       input bit taken, input bit abs_t, input logic [7:0] dout);
    bus.start    = start;
    bus.stall    = stall;
    bus.halt_req = halt;
    bus.br_req   = br;
    bus.br_taken = taken;
    bus.br_abs   = abs_t;
    bus.br_ptr   = 5'($urandom_range(0, 31));
    bus.lut_dout = dout;
  endtask

  task automatic seq();
    drive(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Push the expectation, let one clock edge pass, then pop and compare.
  task automatic cyc(input string tag, input int unsigned pc, input bit flush,
                     input bit busy, input bit done, input int unsigned cnt);
    exp_t e;
    logic [4:0] ptr;
    e.pc = pc; e.flush = flush; e.busy = busy; e.done = done; e.cnt = cnt;
    sb.push_back(e);
    ptr = bus.br_ptr;
    #1;
    check({tag, ".lut_ptr"}, 32'(bus.lut_ptr), 32'(ptr));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_outs(tag, e);
    end
  endtask

  initial begin
    exp_t rst_e;
    rst_e.pc = 0; rst_e.flush = 0; rst_e.busy = 0; rst_e.done = 0; rst_e.cnt = 0;

    rst_n = 1'b0;
    seq();
    #2;
    check_outs("reset", rst_e);
    @(negedge clk);
    rst_n = 1'b1;

    // Start and straight-line fetch up to pc=20.
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc("start", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      seq();
      cyc("seq", i, 0, 1, 0, i);
    end

    // Relative taken branch by -11 from 20, then the flush bubble.
    drive(0, 0, 0, 1, 1, 0, 8'hF5);
    cyc("rel_br", 9, 1, 1, 0, 21);
    drive(0, 0, 1, 1, 1, 1, 8'h33);
    cyc("flush", 9, 0, 1, 0, 21);
    seq();
    cyc("resume", 10, 0, 1, 0, 22);
    drive(0, 0, 0, 1, 0, 0, 8'h40);
    cyc("not_taken", 11, 0, 1, 0, 23);

    // Halt beats a simultaneous taken branch; DONE ignores instruction inputs.
    drive(0, 0, 1, 1, 1, 1, 8'h03);
    cyc("halt_prio", 11, 0, 0, 1, 24);
    drive(0, 0, 1, 1, 1, 0, 8'h07);
    cyc("done_hold", 11, 0, 0, 1, 24);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc("restart", 0, 0, 1, 0, 0);

    // Absolute target 0xEF is unsigned: pc=239.
    for (int i = 1; i <= 3; i++) begin
      seq();
      cyc("seq_b", i, 0, 1, 0, i);
    end
    drive(0, 0, 0, 1, 1, 1, 8'hEF);
    cyc("abs_br", 239, 1, 1, 0, 4);
    seq();
    cyc("abs_flush", 239, 0, 1, 0, 4);
    drive(0, 0, 1, 0, 0, 0, 8'h00);
    cyc("halt", 239, 0, 0, 1, 5);

    // Relative wrap: 2 - 18 mod 1024 = 1008.
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc("restart2", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      seq();
      cyc("seq_c", i, 0, 1, 0, i);
    end
    drive(0, 0, 0, 1, 1, 0, 8'hEE);
    cyc("rel_wrap", 1008, 1, 1, 0, 3);

    // Stall in FLUSH keeps flush high, then stall in RUN freezes everything.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 1, 0, 8'h10);
      cyc("stall_flush", 1008, 1, 1, 0, 3);
    end
    seq();
    cyc("flush_end", 1008, 0, 1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 1, 8'h22);
      cyc("stall_run", 1008, 0, 1, 0, 3);
    end

    // Run to END_ADDR; start in RUN is ignored; fetch past the end finishes.
    for (int p = 1009; p <= 1023; p++) begin
      if (p == 1012) drive(1, 0, 0, 0, 0, 0, 8'h00);
      else seq();
      cyc("seq_end", p, 0, 1, 0, p - 1005);
    end
    seq();
    cyc("end_addr", 1023, 0, 0, 1, 19);

    // Asynchronous reset between edges while in FLUSH.
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc("restart3", 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 8'h05);
    cyc("rel_fwd", 5, 1, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 0, 8'h05);
    cyc("idle_after_rst", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc("restart4", 0, 0, 1, 0, 0);

    // Counter saturates at all-ones (CNT_W=5 -> 31).
    for (int i = 1; i <= 40; i++) begin
      seq();
      cyc("sat", i, 0, 1, 0, (i > 31) ? 31 : i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
